apb_master_arb: RTL and testbench

Two-port APB master that shares one APB bus (one APB slave) between two local requesters. Round-robin arbitration picks a requester, then the block sequences the APB SETUP and ACCESS phases. It honours PREADY wait states, enforces a wait-state timeout, and returns read data or an error to the granted requester. It sits between CPU/DMA-side logic and the APB slave register file.

---
 rtl/apb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 33 +++
 rtl/apb_master_arb.sv | 186 ++++++++++++++++++
 tb/tb_apb_master_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the two-requester APB master: FSM state encoding and
// default bus widths.
package apb_pkg;

    localparam int DEFAULT_DATASIZE = 32;
    localparam int DEFAULT_ADDRSIZE = 32;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester opposite the last
// winner is granted; last_grant only moves when a grant is actually taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    // NOTE: every signal written in a combinational block gets a default first, so no latch can be inferred.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    assign last_grant_d = (advance && (grant != 2'b00)) ? grant[1] : last_grant_q;

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Shares one APB slave between two local requesters: round-robin grant in IDLE,
// then SETUP and ACCESS phases with PREADY wait states and a wait-state timeout.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int DATASIZE = DEFAULT_DATASIZE,
    parameter int ADDRSIZE = DEFAULT_ADDRSIZE,
    parameter int TIMEOUT  = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                req0_valid,
    input  logic                req0_write,
    input  logic [ADDRSIZE-1:0] req0_addr,
    input  logic [DATASIZE-1:0] req0_wdata,
    output logic                req0_ready,
    output logic                rsp0_valid,
    output logic [DATASIZE-1:0] rsp0_rdata,
    output logic                rsp0_err,
    input  logic                req1_valid,
    input  logic                req1_write,
    input  logic [ADDRSIZE-1:0] req1_addr,
    input  logic [DATASIZE-1:0] req1_wdata,
    output logic                req1_ready,
    output logic                rsp1_valid,
    output logic [DATASIZE-1:0] rsp1_rdata,
    output logic                rsp1_err,
    output logic [ADDRSIZE-1:0] PADDR,
    output logic [DATASIZE-1:0] PWDATA,
    output logic                PWRITE,
    output logic                PSEL,
    output logic                PENABLE,
    input  logic [DATASIZE-1:0] PRDATA,
    input  logic                PREADY
);

    localparam int CNTW = $clog2(TIMEOUT) + 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    apb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic [ADDRSIZE-1:0] paddr_q, paddr_d;
    logic [DATASIZE-1:0] pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_err_q, rsp_err_d;
    logic [DATASIZE-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATASIZE-1:0] rsp1_rdata_q, rsp1_rdata_d;

    logic [1:0]          grant;
    logic                in_idle;
    logic                accept;
    logic                ready_seen;
    logic                timeout_hit;
    logic [DATASIZE-1:0] rsp_data;

    assign in_idle = (state_q == APB_IDLE);

    rr_arb2 u_arb (
        .clk     (PCLK),
        .rst     (PRESET),
        .req     ({req1_valid, req0_valid}),
        .advance (in_idle),
        .grant   (grant)
    );

    assign req0_ready = in_idle && grant[0] && req0_valid;
    assign req1_ready = in_idle && grant[1] && req1_valid;
    assign accept     = req0_ready || req1_ready;

    // An X on PREADY fails the equality test and takes the not-ready path.
    always_comb begin
        ready_seen = 1'b0;
        if ((state_q == APB_ACCESS) && (PREADY == 1'b1)) begin
            ready_seen = 1'b1;
        end
    end

    assign timeout_hit = (state_q == APB_ACCESS) && !ready_seen && (cnt_q == CNT_LAST);
    assign rsp_data    = (ready_seen && !pwrite_q) ? PRDATA : '0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= APB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            APB_IDLE:   if (accept) state_d = APB_SETUP;
            APB_SETUP:  state_d = APB_ACCESS;
            APB_ACCESS: if (ready_seen || timeout_hit) state_d = APB_IDLE;
            default:    state_d = APB_IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        cnt_d        = cnt_q;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = 2'b00;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_rdata_d = rsp1_rdata_q;
        case (state_q)
            APB_IDLE: begin
                if (accept) begin
                    owner_d   = grant[1];
                    paddr_d   = grant[1] ? req1_addr  : req0_addr;
                    pwdata_d  = grant[1] ? req1_wdata : req0_wdata;
                    pwrite_d  = grant[1] ? req1_write : req0_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    cnt_d     = '0;
                end
            end
            APB_SETUP: penable_d = 1'b1;
            APB_ACCESS: begin
                if (ready_seen || timeout_hit) begin
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    cnt_d                = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    rsp_err_d[owner_q]   = timeout_hit;
                    if (owner_q) rsp1_rdata_d = rsp_data;
                    else         rsp0_rdata_d = rsp_data;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            owner_q      <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 2'b00;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            owner_q      <= owner_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;
    assign PWRITE     = pwrite_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp1_err   = rsp_err_q[1];
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: a small APB slave with programmable wait
// states, a vector table of single transfers, and hand-written corner sequences.
module tb_apb_master_arb;

    logic        PCLK;
    logic        PRESET;
    logic        req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
    logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
    logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSEL, PENABLE, PREADY;

    int n_tests = 0;
    int n_fail  = 0;

    apb_master_arb #(.DATASIZE(32), .ADDRSIZE(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
        .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
        .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave: 16-word memory, PREADY rises after slave_waits not-ready ACCESS cycles.
    logic [31:0] mem [16] = '{default: '0};
    int          wait_cnt = 0;
    int          slave_waits = 0;

    assign PREADY = PSEL && PENABLE && (wait_cnt >= slave_waits);
    assign PRDATA = mem[PADDR[5:2]];

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) wait_cnt <= wait_cnt + 1;
        else                            wait_cnt <= 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
    end

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          exp_acc;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic drive_req(input int port, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            req0_valid = 1'b1; req0_write = wr; req0_addr = addr; req0_wdata = wdata;
        end else begin
            req1_valid = 1'b1; req1_write = wr; req1_addr = addr; req1_wdata = wdata;
        end
    endtask

    task automatic run_xfer(input vec_t v, input int idx);
        int  acc;
        bit  got;
        string tag;
        tag = $sformatf("vec%0d", idx);
        slave_waits = v.waits;
        drive_req(v.port, v.wr, v.addr, v.wdata);
        #1;
        check({tag, " ready"}, (v.port == 0) ? req0_ready : req1_ready, 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, " setup psel/penable"}, {PSEL, PENABLE}, 2'b10);
        check({tag, " paddr"}, PADDR, v.addr);
        check({tag, " pwrite"}, PWRITE, v.wr);
        if (v.wr) check({tag, " pwdata"}, PWDATA, v.wdata);
        tick();
        check({tag, " access penable"}, PENABLE, 1);
        acc = 1;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if ((v.port == 0) ? rsp0_valid : rsp1_valid) begin
                got = 1'b1;
                break;
            end
            acc++;
        end
        check({tag, " rsp seen"}, got, 1);
        check({tag, " access cycles"}, acc, v.exp_acc);
        check({tag, " rsp err"}, (v.port == 0) ? rsp0_err : rsp1_err, v.exp_err);
        check({tag, " rsp rdata"}, (v.port == 0) ? rsp0_rdata : rsp1_rdata, v.exp_rdata);
        check({tag, " other rsp quiet"}, (v.port == 0) ? rsp1_valid : rsp0_valid, 0);
        check({tag, " psel dropped"}, {PSEL, PENABLE}, 2'b00);
        tick();
        check({tag, " rsp one-shot"}, (v.port == 0) ? rsp0_valid : rsp1_valid, 0);
        check({tag, " rdata hold"}, (v.port == 0) ? rsp0_rdata : rsp1_rdata, v.exp_rdata);
    endtask

    initial begin
        int k;
        int n_rdy0, n_rdy1, n_rsp;
        bit got;

        vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 0,    32'h0000_0000, 1'b0, 1};
        vecs[1] = '{1, 1'b0, 32'h0000_0010, 32'h0,         0,    32'hA5A5_0001, 1'b0, 1};
        vecs[2] = '{0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3,    32'h0000_0000, 1'b0, 4};
        vecs[3] = '{1, 1'b0, 32'h0000_0020, 32'h0,         3,    32'h1234_5678, 1'b0, 4};
        vecs[4] = '{0, 1'b0, 32'h0000_0030, 32'h0,         1000, 32'h0000_0000, 1'b1, 16};
        vecs[5] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 2,    32'h0000_0000, 1'b0, 3};
        vecs[6] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         1,    32'hDEAD_BEEF, 1'b0, 2};
        vecs[7] = '{1, 1'b0, 32'h0000_0010, 32'h0,         0,    32'hA5A5_0001, 1'b0, 1};

        PRESET = 1'b1;
        req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        #1;
        check("reset psel/penable/pwrite", {PSEL, PENABLE, PWRITE}, 3'b000);
        check("reset paddr", PADDR, 0);
        check("reset pwdata", PWDATA, 0);
        check("reset rsp", {rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}, 4'b0000);
        check("reset rdata", {rsp0_rdata, rsp1_rdata}, 0);
        check("reset ready", {req0_ready, req1_ready}, 2'b00);

        // Both requesters continuously valid: grants must alternate starting with 0.
        slave_waits = 0;
        drive_req(0, 1'b1, 32'h0000_0100, 32'h0000_0001);
        drive_req(1, 1'b1, 32'h0000_0104, 32'h0000_0002);
        k = 0; n_rdy0 = 0; n_rdy1 = 0; n_rsp = 0;
        for (int c = 0; c < 30 && k < 4; c++) begin
            #1;
            n_rsp += int'(rsp0_valid) + int'(rsp1_valid);
            if (req0_ready || req1_ready) begin
                check($sformatf("rr single ready %0d", k), req0_ready && req1_ready, 0);
                check($sformatf("rr grant %0d", k), req1_ready, k % 2);
                n_rdy0 += int'(req0_ready);
                n_rdy1 += int'(req1_ready);
                k++;
            end
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_rsp += int'(rsp0_valid) + int'(rsp1_valid);
            n_rdy0 += int'(req0_ready);
            n_rdy1 += int'(req1_ready);
            tick();
        end
        check("rr transfers", k, 4);
        check("rr ready0 pulses", n_rdy0, 2);
        check("rr ready1 pulses", n_rdy1, 2);
        check("rr responses", n_rsp, 4);

        for (int i = 0; i < 8; i++) run_xfer(vecs[i], i);

        // Requester 1 waits while requester 0 is in flight, then its address is held.
        slave_waits = 2;
        drive_req(0, 1'b1, 32'h0000_0050, 32'h0000_5050);
        #1 check("stall req0 ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        drive_req(1, 1'b0, 32'h0000_0064, 32'h0);
        #1 check("stall req1 blocked setup", req1_ready, 0);
        got = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (rsp0_valid) begin
                got = 1'b1;
                break;
            end
            check("stall req1 blocked access", req1_ready, 0);
        end
        check("stall req0 rsp seen", got, 1);
        check("stall req1 ready in idle", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        req1_addr  = 32'hDEAD_0000;
        check("stall setup paddr", PADDR, 32'h0000_0064);
        got = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (rsp1_valid) begin
                got = 1'b1;
                break;
            end
            check("stall access paddr", PADDR, 32'h0000_0064);
            check("stall access penable", PENABLE, 1);
        end
        check("stall req1 rsp seen", got, 1);
        check("stall req1 rsp err", rsp1_err, 0);
        check("stall req1 rdata", rsp1_rdata, 0);
        tick();
        check("idle paddr hold", PADDR, 32'h0000_0064);

        // Reset in a wait state: bus drops at once, no response, arbiter restarts at 0.
        slave_waits = 1000;
        drive_req(0, 1'b0, 32'h0000_0030, 32'h0);
        #1 check("rst-mid req0 ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        check("rst-mid in access", {PSEL, PENABLE}, 2'b11);
        #2 PRESET = 1'b1;
        #1;
        check("rst-mid psel/penable", {PSEL, PENABLE}, 2'b00);
        check("rst-mid paddr", PADDR, 0);
        check("rst-mid no rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        slave_waits = 0;
        check("post-rst no rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        drive_req(0, 1'b1, 32'h0000_0070, 32'h0000_0007);
        drive_req(1, 1'b1, 32'h0000_0074, 32'h0000_0008);
        #1 check("post-rst grant", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("post-rst paddr", PADDR, 32'h0000_0070);
        repeat (2) tick();
        check("post-rst rsp", {rsp1_valid, rsp0_valid, rsp0_err}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
